// File: rtl/ahb_read_dma_master.sv
// ---------------------------------------------------------------------------
// ahb_read_dma_master
//
// AHB-Lite read-only DMA master. A one-cycle i_start request latches a start
// address and a byte length. The block then issues an INCR read burst of
// ceil(i_len / (DATA_W/8)) beats with pipelined address and data phases, and
// returns each beat on o_rdata/o_rdata_valid. The address steps up or down by
// one beat per accepted transfer. The step direction is a parameter, and the
// address wraps modulo 2^32. A beat whose next address falls into a new 1 KB
// page is issued as NONSEQ. A two-cycle ERROR response cancels the remaining
// beats and finishes the transfer with o_done and o_error together.
//
// Parameters
//   DATA_W     beat width in bits (32 or 64)
//   LEN_W      width of the byte-length input and of the beat counter
//   ADDR_DOWN  0 = incrementing addresses, 1 = decrementing addresses
//
// Ports
//   HCLK           bus clock, rising-edge active
//   HRESET         synchronous active-high reset
//   i_start        one-cycle transfer request, honoured only when idle
//   i_addr         start byte address, beat-aligned
//   i_len          transfer length in bytes (0 = no bus activity)
//   o_busy         transfer in progress (cycle after start through o_done)
//   o_done         one-cycle completion pulse
//   o_error        one-cycle pulse with o_done when aborted by ERROR
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST  AHB-Lite address-phase outputs
//   HRDATA/HREADY/HRESP               AHB-Lite slave response
//   o_rdata        registered read beat
//   o_rdata_valid  one-cycle qualifier for o_rdata
// ---------------------------------------------------------------------------
module ahb_read_dma_master #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter bit          ADDR_DOWN = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              i_start,
  input  logic [31:0]       i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid
);

  localparam int unsigned BPB    = DATA_W / 8;
  localparam int unsigned BSHIFT = (DATA_W == 64) ? 3 : 2;
  localparam logic [31:0] STEP   = ADDR_DOWN ? (32'd0 - 32'(BPB)) : 32'(BPB);
  localparam logic [2:0]  SIZE   = (DATA_W == 64) ? 3'b011 : 3'b010;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [31:0]       haddr_q;
  logic [1:0]        htrans_q;
  logic [2:0]        hsize_q;
  logic [LEN_W-1:0]  acnt;       // addresses still to be accepted
  logic              dphase;     // a beat is currently in its data phase
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              done_q;
  logic              error_q;

  logic [LEN_W:0]    len_round;
  logic [LEN_W-1:0]  beats;
  logic [31:0]       addr_next;
  logic              page_cross;
  logic              addr_accept;
  logic              err_first;
  logic              err_last;
  logic              beat_ok;

  // Beat count rounded up; one extra bit keeps the rounding add from overflowing.
  always_comb begin
    len_round = {1'b0, i_len} + (LEN_W+1)'(BPB - 1);
    beats     = LEN_W'(len_round >> BSHIFT);
  end

  assign addr_next  = haddr_q + STEP;
  assign page_cross = (addr_next[31:10] != haddr_q[31:10]);

  assign err_first = dphase && HRESP && !HREADY;
  assign err_last  = dphase && HRESP &&  HREADY;
  assign beat_ok   = dphase && HREADY && !HRESP;

  // The pending address phase is withdrawn to IDLE in the first ERROR cycle
  // itself, so HTRANS is masked combinationally rather than waiting a clock.
  assign HTRANS      = (dphase && HRESP) ? TR_IDLE : htrans_q;
  assign addr_accept = HREADY && HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= TR_IDLE;
      hsize_q  <= '0;
      acnt     <= '0;
      dphase   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      rvalid_q <= beat_ok;
      if (beat_ok) begin
        rdata_q <= HRDATA;
      end
      done_q  <= 1'b0;
      error_q <= 1'b0;

      // An accepted address opens a data phase; a completed data phase with
      // no new address closes it.
      if (HREADY) begin
        dphase <= addr_accept;
      end

      if (err_last) begin
        htrans_q <= TR_IDLE;
        state    <= S_DONE;
        done_q   <= 1'b1;
        error_q  <= 1'b1;
      end else if (err_first) begin
        htrans_q <= TR_IDLE;
        state    <= S_LAST;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              acnt <= beats;
              if (beats == '0) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                haddr_q  <= i_addr;
                hsize_q  <= SIZE;
                htrans_q <= TR_NONSEQ;
                state    <= S_FIRST;
              end
            end
          end
          S_FIRST, S_BURST: begin
            if (addr_accept) begin
              acnt <= acnt - LEN_W'(1);
              if (acnt == LEN_W'(1)) begin
                htrans_q <= TR_IDLE;
                state    <= S_LAST;
              end else begin
                haddr_q  <= addr_next;
                htrans_q <= page_cross ? TR_NONSEQ : TR_SEQ;
                state    <= S_BURST;
              end
            end
          end
          S_LAST: begin
            if (!dphase || HREADY) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign HADDR         = haddr_q;
  assign HSIZE         = hsize_q;
  assign HWRITE        = 1'b0;
  assign HBURST        = 3'b001;
  assign o_busy        = (state != S_IDLE);
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q;

endmodule
